// File: rtl/branch_cond_unit.sv
// Branch condition unit: internal flag register, generalised condition evaluation,
// registered jump decision to fetch over valid/ready, and a post-jump flush window.
module branch_cond_unit #(
    parameter int FLAG_W    = 8,
    parameter int SEL_W     = 4,
    parameter int ADDR_W    = 16,
    parameter int FLUSH_CYC = 2,
    parameter int BYPASS    = 1
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [FLAG_W-1:0] flag_we,
    input  logic [FLAG_W-1:0] flag_d,
    output logic [FLAG_W-1:0] flags_o,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_inv,
    input  logic [SEL_W-1:0]  req_sel,
    input  logic [ADDR_W-1:0] req_target,
    output logic              jmp_valid,
    output logic              jmp_taken,
    output logic [ADDR_W-1:0] jmp_target,
    input  logic              jmp_ready,
    output logic              flush_o
);

    localparam int CNT_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
    localparam int SEL_N = 2 ** SEL_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t            state_r, state_next_s;
    logic [FLAG_W-1:0] flags_r, flags_next_s, flags_eff_s;
    logic [SEL_N-1:0]  cond_vec_s;
    logic              cond_s;
    logic              jmp_valid_r, jmp_valid_next_s;
    logic              jmp_taken_r, jmp_taken_next_s;
    logic [ADDR_W-1:0] jmp_target_r, jmp_target_next_s;
    logic              flush_r, flush_next_s;
    logic [CNT_W-1:0]  cnt_r, cnt_next_s;

    // Masked flag write and condition lookup (bit 0 of the table is the "always" entry)
    always_comb begin
        flags_next_s = (flags_r & ~flag_we) | (flag_d & flag_we);
        flags_eff_s  = (BYPASS != 0) ? flags_next_s : flags_r;
        cond_vec_s   = '0;
        cond_vec_s[FLAG_W:0] = {flags_eff_s, 1'b1};
        cond_s       = cond_vec_s[req_sel] ^ req_inv;
    end

    // Next-state and next-output logic
    always_comb begin
        state_next_s      = state_r;
        jmp_valid_next_s  = jmp_valid_r;
        jmp_taken_next_s  = jmp_taken_r;
        jmp_target_next_s = jmp_target_r;
        flush_next_s      = flush_r;
        cnt_next_s        = cnt_r;
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    jmp_taken_next_s  = cond_s;
                    jmp_target_next_s = req_target;
                    jmp_valid_next_s  = 1'b1;
                    state_next_s      = HOLD;
                end else begin
                    state_next_s = IDLE;
                end
            end
            HOLD: begin
                if (jmp_ready) begin
                    jmp_valid_next_s = 1'b0;
                    if (jmp_taken_r) begin
                        flush_next_s = 1'b1;
                        cnt_next_s   = CNT_W'(FLUSH_CYC - 1);
                        state_next_s = FLUSH;
                    end else begin
                        state_next_s = IDLE;
                    end
                end else begin
                    state_next_s = HOLD;
                end
            end
            FLUSH: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    flush_next_s = 1'b0;
                    state_next_s = IDLE;
                end else begin
                    cnt_next_s = cnt_r - CNT_W'(1);
                end
            end
            default: begin
                state_next_s     = IDLE;
                jmp_valid_next_s = 1'b0;
                flush_next_s     = 1'b0;
                cnt_next_s       = {CNT_W{1'b0}};
            end
        endcase
    end

    // State, flag and output registers
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_r      <= IDLE;
            flags_r      <= {FLAG_W{1'b0}};
            jmp_valid_r  <= 1'b0;
            jmp_taken_r  <= 1'b0;
            jmp_target_r <= {ADDR_W{1'b0}};
            flush_r      <= 1'b0;
            cnt_r        <= {CNT_W{1'b0}};
        end else begin
            state_r      <= state_next_s;
            flags_r      <= flags_next_s;
            jmp_valid_r  <= jmp_valid_next_s;
            jmp_taken_r  <= jmp_taken_next_s;
            jmp_target_r <= jmp_target_next_s;
            flush_r      <= flush_next_s;
            cnt_r        <= cnt_next_s;
        end
    end

    assign req_ready  = (state_r == IDLE);
    assign flags_o    = flags_r;
    assign jmp_valid  = jmp_valid_r;
    assign jmp_taken  = jmp_taken_r;
    assign jmp_target = jmp_target_r;
    assign flush_o    = flush_r;

endmodule

// File: tb/tb_branch_cond_unit.sv
// Self-checking bench for branch_cond_unit: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level reference model.
module tb_branch_cond_unit;

    localparam int FLAG_W    = 8;
    localparam int SEL_W     = 4;
    localparam int ADDR_W    = 16;
    localparam int FLUSH_CYC = 2;
    localparam int BYPASS    = 1;

    logic              clk = 1'b0;
    logic              nrst;
    logic [FLAG_W-1:0] flag_we, flag_d, flags_o;
    logic              req_valid, req_ready, req_inv;
    logic [SEL_W-1:0]  req_sel;
    logic [ADDR_W-1:0] req_target;
    logic              jmp_valid, jmp_taken, jmp_ready, flush_o;
    logic [ADDR_W-1:0] jmp_target;

    int checks_cnt = 0;
    int fail_cnt   = 0;

    // Reference model state: outstanding decision and remaining flush cycles
    int unsigned m_flags;
    bit          m_have;
    bit          m_taken;
    int unsigned m_target;
    int          m_flush_left;

    branch_cond_unit #(
        .FLAG_W(FLAG_W), .SEL_W(SEL_W), .ADDR_W(ADDR_W),
        .FLUSH_CYC(FLUSH_CYC), .BYPASS(BYPASS)
    ) dut (
        .clk(clk), .nrst(nrst), .flag_we(flag_we), .flag_d(flag_d), .flags_o(flags_o),
        .req_valid(req_valid), .req_ready(req_ready), .req_inv(req_inv),
        .req_sel(req_sel), .req_target(req_target), .jmp_valid(jmp_valid),
        .jmp_taken(jmp_taken), .jmp_target(jmp_target), .jmp_ready(jmp_ready),
        .flush_o(flush_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit model_cond(int unsigned flags, int sel, bit inv);
        bit raw;
        if (sel == 0) raw = 1'b1;
        else if (sel <= FLAG_W) raw = ((flags >> (sel - 1)) % 2) == 1;
        else raw = 1'b0;
        return raw ^ inv;
    endfunction

    task automatic model_reset();
        m_flags = 0; m_have = 0; m_taken = 0; m_target = 0; m_flush_left = 0;
    endtask

    task automatic check_all();
        check_eq("flags_o",    32'(flags_o),    32'(m_flags));
        check_eq("jmp_valid",  32'(jmp_valid),  32'(m_have));
        check_eq("jmp_taken",  32'(jmp_taken),  32'(m_taken));
        check_eq("jmp_target", 32'(jmp_target), 32'(m_target));
        check_eq("flush_o",    32'(flush_o),    32'(m_flush_left > 0));
        check_eq("req_ready",  32'(req_ready),  32'(!m_have && m_flush_left == 0));
    endtask

    // One clock: drive inputs, advance model, then compare on the falling edge
    task automatic cycle(input int we, input int d, input bit v, input int sel, input bit inv,
                         input int tgt, input bit jr);
        int unsigned nf, eff;
        flag_we = FLAG_W'(we); flag_d = FLAG_W'(d); req_valid = v;
        req_sel = SEL_W'(sel); req_inv = inv; req_target = ADDR_W'(tgt); jmp_ready = jr;
        nf  = (m_flags & ~32'(we) | 32'(d) & 32'(we)) & 32'hFF;
        eff = (BYPASS != 0) ? nf : m_flags;
        if (!m_have && m_flush_left == 0) begin
            if (v) begin
                m_have = 1; m_taken = model_cond(eff, sel, inv); m_target = 32'(tgt) & 32'hFFFF;
            end
        end else if (m_have) begin
            if (jr) begin
                m_have = 0;
                if (m_taken) m_flush_left = FLUSH_CYC;
            end
        end else begin
            m_flush_left--;
        end
        m_flags = nf;
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    // Issue one request, accept it, and drain any flush window
    task automatic run_req(input int sel, input bit inv, input bit exp_taken, input string tag);
        cycle(0, 0, 1, sel, inv, 16'h0BEE, 0);
        check_eq(tag, 32'(jmp_taken), 32'(exp_taken));
        cycle(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 6 && !req_ready; i++) cycle(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int jv_cnt, fl_cnt, fl_seen;
        nrst = 1'b0; flag_we = '0; flag_d = '0; req_valid = 0; req_inv = 0;
        req_sel = '0; req_target = '0; jmp_ready = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        nrst = 1'b1;
        @(negedge clk);
        check_all();

        // Masked flag writes
        cycle(8'hFF, 8'hA5, 0, 0, 0, 0, 0);
        check_eq("flags_a5", 32'(flags_o), 32'hA5);
        cycle(8'h0F, 8'h00, 0, 0, 0, 0, 0);
        check_eq("flags_a0", 32'(flags_o), 32'hA0);
        #2 nrst = 1'b0;
        #1 check_eq("flags_async_rst", 32'(flags_o), 32'h0);
        model_reset();
        @(negedge clk); nrst = 1'b1;

        // Condition decoding with flags = 0x40
        cycle(8'hFF, 8'h40, 0, 0, 0, 0, 0);
        run_req(7, 0, 1, "cond_sel7");
        run_req(7, 1, 0, "cond_sel7_inv");
        run_req(0, 0, 1, "cond_always");
        run_req(0, 1, 0, "cond_never");
        run_req(9, 0, 0, "cond_sel9");
        run_req(9, 1, 1, "cond_sel9_inv");

        // Same-cycle flag write visible to the request only with bypass
        cycle(8'hFF, 8'h00, 0, 0, 0, 0, 0);
        cycle(8'h01, 8'h01, 1, 1, 0, 16'h0042, 0);
        check_eq("bypass_taken", 32'(jmp_taken), 32'(BYPASS != 0));
        cycle(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 6 && !req_ready; i++) cycle(0, 0, 0, 0, 0, 0, 0);

        // Backpressure then flush window
        cycle(0, 0, 1, 0, 0, 16'h1234, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(8'hFF, 32'(i * 37), 1, 0, 1, 16'h5555, 0);
            check_eq("bp_target", 32'(jmp_target), 32'h1234);
            check_eq("bp_valid", 32'(jmp_valid), 32'h1);
            check_eq("bp_ready", 32'(req_ready), 32'h0);
        end
        cycle(0, 0, 0, 0, 0, 0, 1);
        fl_cnt = 0;
        for (int i = 0; i < 10 && flush_o; i++) begin
            fl_cnt++;
            cycle(0, 0, 0, 0, 0, 0, 0);
        end
        check_eq("flush_len", 32'(fl_cnt), 32'(FLUSH_CYC));
        check_eq("ready_after_flush", 32'(req_ready), 32'h1);

        // Not-taken back-to-back stream
        cycle(8'h01, 8'h00, 0, 0, 0, 0, 1);
        jv_cnt = 0; fl_seen = 0;
        for (int i = 0; i < 8; i++) begin
            cycle(0, 0, 1, 1, 0, 16'h0100 + i, 1);
            jv_cnt += int'(jmp_valid);
            fl_seen += int'(flush_o);
        end
        check_eq("nt_valid_count", 32'(jv_cnt), 32'd4);
        check_eq("nt_no_flush", 32'(fl_seen), 32'd0);
        for (int i = 0; i < 4 && !req_ready; i++) cycle(0, 0, 0, 0, 0, 0, 1);

        // Reset on the first flush cycle
        cycle(0, 0, 1, 0, 0, 16'hBEEF, 0);
        cycle(0, 0, 0, 0, 0, 0, 1);
        check_eq("pre_rst_flush", 32'(flush_o), 32'h1);
        #2 nrst = 1'b0;
        #1;
        check_eq("rst_flush", 32'(flush_o), 32'h0);
        check_eq("rst_valid", 32'(jmp_valid), 32'h0);
        model_reset();
        @(negedge clk); nrst = 1'b1;
        @(negedge clk);
        check_all();
        check_eq("rst_ready", 32'(req_ready), 32'h1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 255), $urandom_range(0, 255), ($urandom_range(0, 3) != 0),
                  $urandom_range(0, 15), $urandom_range(0, 1), $urandom_range(0, 65535),
                  ($urandom_range(0, 2) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule
